// File: rtl/wbxbc_error_responder_if.sv
// Wishbone-style bus bundle used on both the initiator and target side of the
// WbXbc error responder; master drives the request, slave drives the response.
interface wbxbc_error_responder_if #(
  parameter int TGT_CNT    = 4,
  parameter int ADR_WIDTH  = 16,
  parameter int DAT_WIDTH  = 16,
  parameter int SEL_WIDTH  = 2,
  parameter int TGA_WIDTH  = 1,
  parameter int TGC_WIDTH  = 1,
  parameter int TGRD_WIDTH = 1,
  parameter int TGWD_WIDTH = 1
) ();

  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic                  lock;
  logic [SEL_WIDTH-1:0]  sel;
  logic [ADR_WIDTH-1:0]  adr;
  logic [DAT_WIDTH-1:0]  dat_w;
  logic [TGA_WIDTH-1:0]  tga;
  logic [TGT_CNT-1:0]    tga_tgtsel;
  logic [TGC_WIDTH-1:0]  tgc;
  logic [TGWD_WIDTH-1:0] tgd_w;

  logic                  ack;
  logic                  err;
  logic                  rty;
  logic                  stall;
  logic [DAT_WIDTH-1:0]  dat_r;
  logic [TGRD_WIDTH-1:0] tgd_r;

  modport master (
    output cyc, stb, we, lock, sel, adr, dat_w, tga, tga_tgtsel, tgc, tgd_w,
    input  ack, err, rty, stall, dat_r, tgd_r
  );

  modport slave (
    input  cyc, stb, we, lock, sel, adr, dat_w, tga, tga_tgtsel, tgc, tgd_w,
    output ack, err, rty, stall, dat_r, tgd_r
  );

endinterface

// File: rtl/wbxbc_error_responder.sv
// Forwards target-selected accesses with zero latency and answers accesses with
// no target selected by itself (ERR or RTY), once all forwarded accesses retire.
module wbxbc_error_responder #(
  parameter int TGT_CNT         = 4,
  parameter int ADR_WIDTH       = 16,
  parameter int DAT_WIDTH       = 16,
  parameter int SEL_WIDTH       = 2,
  parameter int TGA_WIDTH       = 1,
  parameter int TGC_WIDTH       = 1,
  parameter int TGRD_WIDTH      = 1,
  parameter int TGWD_WIDTH      = 1,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ERR_LATENCY     = 1,
  parameter int RTY_MODE        = 0,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                     clk_i,
  input  logic                     sync_rst_i,
  wbxbc_error_responder_if.slave   itr,
  wbxbc_error_responder_if.master  tgt,
  input  logic                     err_clr_i,
  output logic [CNT_WIDTH-1:0]     err_cnt_o,
  output logic [ADR_WIDTH-1:0]     err_adr_o
);

  localparam int OCW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OCW-1:0] OUT_MAX = OCW'(MAX_OUTSTANDING);
  localparam int DLY_INIT = (ERR_LATENCY > 1) ? ERR_LATENCY - 2 : 0;
  localparam int DLW = (DLY_INIT > 0) ? $clog2(DLY_INIT + 1) : 1;
  localparam bit GEN_RTY = (RTY_MODE != 0);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_RESP} state_t;

  typedef struct packed {
    logic                  we;
    logic                  lock;
    logic [SEL_WIDTH-1:0]  sel;
    logic [ADR_WIDTH-1:0]  adr;
    logic [DAT_WIDTH-1:0]  dat;
    logic [TGA_WIDTH-1:0]  tga;
    logic [TGT_CNT-1:0]    tgtsel;
    logic [TGC_WIDTH-1:0]  tgc;
    logic [TGWD_WIDTH-1:0] tgd;
  } fwd_t;

  typedef struct packed {
    logic [DAT_WIDTH-1:0]  dat;
    logic [TGRD_WIDTH-1:0] tgd;
  } rd_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t         state;
  logic [OCW-1:0] out_cnt;
  logic [DLW-1:0] dly_cnt;

  fwd_t fwd_req;
  rd_t  rd_rsp;
  logic run;
  logic req;
  logic mapped;
  logic idle;
  logic full;
  logic empty;
  logic fwd_beat;
  logic tgt_rsp;
  logic accept;
  logic gen;
  logic stall_c;

  assign fwd_req.we     = itr.we;
  assign fwd_req.lock   = itr.lock;
  assign fwd_req.sel    = itr.sel;
  assign fwd_req.adr    = itr.adr;
  assign fwd_req.dat    = itr.dat_w;
  assign fwd_req.tga    = itr.tga;
  assign fwd_req.tgtsel = itr.tga_tgtsel;
  assign fwd_req.tgc    = itr.tgc;
  assign fwd_req.tgd    = itr.tgd_w;

  assign tgt.we         = fwd_req.we;
  assign tgt.lock       = fwd_req.lock;
  assign tgt.sel        = fwd_req.sel;
  assign tgt.adr        = fwd_req.adr;
  assign tgt.dat_w      = fwd_req.dat;
  assign tgt.tga        = fwd_req.tga;
  assign tgt.tga_tgtsel = fwd_req.tgtsel;
  assign tgt.tgc        = fwd_req.tgc;
  assign tgt.tgd_w      = fwd_req.tgd;

  assign rd_rsp.dat = tgt.dat_r;
  assign rd_rsp.tgd = tgt.tgd_r;
  assign itr.dat_r  = rd_rsp.dat;
  assign itr.tgd_r  = rd_rsp.tgd;

  // sync_rst_i is active-low: run is high whenever the block is out of reset
  assign run    = sync_rst_i;
  assign req    = itr.cyc & itr.stb;
  assign mapped = |fwd_req.tgtsel;
  assign idle   = (state == S_IDLE);
  assign full   = (out_cnt == OUT_MAX);
  assign empty  = (out_cnt == '0);

  assign tgt.cyc  = run & itr.cyc;
  assign tgt.stb  = run & req & mapped & idle & ~full;
  assign fwd_beat = tgt.cyc & tgt.stb & ~tgt.stall;
  assign tgt_rsp  = tgt.ack | tgt.err | tgt.rty;

  // An unmapped access is only taken once every forwarded access has retired,
  // which keeps generated and target responses from ever colliding.
  assign accept = run & req & ~mapped & idle & empty;
  assign gen    = run & itr.cyc & (state == S_RESP);

  always_comb begin
    stall_c = 1'b1;
    if (run && idle) begin
      if (mapped) stall_c = tgt.stall | full;
      else        stall_c = ~empty;
    end
  end

  assign itr.stall = stall_c;
  assign itr.ack   = tgt.ack;
  assign itr.err   = tgt.err | (gen & ~GEN_RTY);
  assign itr.rty   = tgt.rty | (gen & GEN_RTY);

  always_ff @(posedge clk_i) begin
    if (!sync_rst_i) begin
      state     <= S_IDLE;
      out_cnt   <= '0;
      dly_cnt   <= '0;
      err_cnt_o <= '0;
      err_adr_o <= '0;
    end else begin
      // Simultaneous issue and retire leaves the count unchanged; a stray
      // response with nothing outstanding is passed on but not counted.
      if (!itr.cyc)                          out_cnt <= '0;
      else if (fwd_beat && !tgt_rsp)         out_cnt <= out_cnt + 1'b1;
      else if (tgt_rsp && !fwd_beat && !empty) out_cnt <= out_cnt - 1'b1;

      if (err_clr_i)  err_cnt_o <= gen ? CNT_WIDTH'(1) : '0;
      else if (gen)   err_cnt_o <= sat_inc(err_cnt_o);

      if (accept) err_adr_o <= itr.adr;

      if (!itr.cyc) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              if (ERR_LATENCY > 1) begin
                state   <= S_DELAY;
                dly_cnt <= DLW'(DLY_INIT);
              end else begin
                state <= S_RESP;
              end
            end
          end
          S_DELAY: begin
            if (dly_cnt == '0) state <= S_RESP;
            else               dly_cnt <= dly_cnt - 1'b1;
          end
          S_RESP:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wbxbc_error_responder.sv
// Two responder configurations driven by one stimulus stream and checked each
// cycle against a timestamp-based reference model, plus directed corner cases.
module tb_wbxbc_error_responder;

  // dut0: ERR, latency 1, 2 outstanding, 2-bit counter; dut1: RTY, latency 3, 4 outstanding
  localparam int P_L    [2] = '{1, 3};
  localparam int P_RTY  [2] = '{0, 1};
  localparam int P_MAX  [2] = '{2, 4};
  localparam int P_CW   [2] = '{2, 8};
  localparam int P_CMAX [2] = '{3, 255};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, cyc, stb, we, lock, tga, tgc, tgdw, clr;
  logic [1:0]  sel;
  logic [15:0] adr, dat;
  logic [3:0]  tgtsel;
  logic        t_ack, t_err, t_rty, t_stall, t_tgd;
  logic [15:0] t_dat;

  logic [1:0]       d_tcyc, d_tstb, d_stall, d_ack, d_err, d_rty;
  logic [1:0][15:0] d_dato, d_tadr, d_eadr;
  logic [1:0][7:0]  d_cnt;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int CW = P_CW[g];
    logic [CW-1:0] cnt_l;
    wbxbc_error_responder_if bus_i ();
    wbxbc_error_responder_if bus_t ();

    assign bus_i.cyc = cyc;      assign bus_i.stb = stb;
    assign bus_i.we = we;        assign bus_i.lock = lock;
    assign bus_i.sel = sel;      assign bus_i.adr = adr;
    assign bus_i.dat_w = dat;    assign bus_i.tga = tga;
    assign bus_i.tga_tgtsel = tgtsel;
    assign bus_i.tgc = tgc;      assign bus_i.tgd_w = tgdw;
    assign bus_t.ack = t_ack;    assign bus_t.err = t_err;
    assign bus_t.rty = t_rty;    assign bus_t.stall = t_stall;
    assign bus_t.dat_r = t_dat;  assign bus_t.tgd_r = t_tgd;

    assign d_tcyc[g]  = bus_t.cyc;
    assign d_tstb[g]  = bus_t.stb;
    assign d_tadr[g]  = bus_t.adr;
    assign d_stall[g] = bus_i.stall;
    assign d_ack[g]   = bus_i.ack;
    assign d_err[g]   = bus_i.err;
    assign d_rty[g]   = bus_i.rty;
    assign d_dato[g]  = bus_i.dat_r;
    assign d_cnt[g]   = 8'(cnt_l);

    wbxbc_error_responder #(
      .MAX_OUTSTANDING (P_MAX[g]),
      .ERR_LATENCY     (P_L[g]),
      .RTY_MODE        (P_RTY[g]),
      .CNT_WIDTH       (CW)
    ) u_dut (
      .clk_i      (clk),
      .sync_rst_i (rst_n),
      .itr        (bus_i),
      .tgt        (bus_t),
      .err_clr_i  (clr),
      .err_cnt_o  (cnt_l),
      .err_adr_o  (d_eadr[g])
    );
  end

  int checks = 0;
  int failures = 0;

  // Reference model: outstanding count, interval index of the pending
  // generated response (-1 when none), fault count and last fault address.
  int now = 0;
  int m_out [2] = '{0, 0};
  int m_resp[2] = '{-1, -1};
  int m_cnt [2] = '{0, 0};
  int m_adr [2] = '{0, 0};

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t got=%0h want=%0h", name, d, $time, act, exp);
    end
  endtask

  // Called right after a negedge with inputs driven; checks, advances the
  // model across the next posedge and returns at the following negedge.
  task automatic step();
    #2;
    for (int d = 0; d < 2; d++) begin
      bit mapped, rq, busy, gen, tstb, stall_e, fwd, rsp, acc;
      mapped  = |tgtsel;
      rq      = cyc & stb;
      busy    = (m_resp[d] >= now);
      gen     = rst_n && cyc && busy && (now == m_resp[d]);
      tstb    = rst_n && rq && mapped && !busy && (m_out[d] < P_MAX[d]);
      stall_e = !rst_n || busy || (mapped ? (t_stall || m_out[d] == P_MAX[d]) : (m_out[d] != 0));
      chk("tgt_cyc", d, d_tcyc[d], rst_n & cyc);
      chk("tgt_stb", d, d_tstb[d], tstb);
      chk("tgt_adr", d, d_tadr[d], adr);
      chk("stall",   d, d_stall[d], stall_e);
      chk("ack",     d, d_ack[d], t_ack);
      chk("err",     d, d_err[d], t_err | (gen && P_RTY[d] == 0));
      chk("rty",     d, d_rty[d], t_rty | (gen && P_RTY[d] != 0));
      chk("dat_o",   d, d_dato[d], t_dat);
      chk("err_cnt", d, d_cnt[d], m_cnt[d]);
      chk("err_adr", d, d_eadr[d], m_adr[d]);
      if (!rst_n) begin
        m_out[d] = 0; m_resp[d] = -1; m_cnt[d] = 0; m_adr[d] = 0;
      end else begin
        fwd = tstb && !t_stall;
        rsp = t_ack || t_err || t_rty;
        acc = rq && !mapped && !busy && (m_out[d] == 0);
        if (clr)                           m_cnt[d] = gen ? 1 : 0;
        else if (gen && m_cnt[d] < P_CMAX[d]) m_cnt[d]++;
        if (!cyc)                          m_out[d] = 0;
        else if (fwd && !rsp)              m_out[d]++;
        else if (rsp && !fwd && m_out[d] > 0) m_out[d]--;
        if (!cyc)      m_resp[d] = -1;
        else if (acc) begin
          m_adr[d]  = adr;
          m_resp[d] = now + P_L[d];
        end
      end
    end
    now++;
    @(negedge clk);
  endtask

  task automatic bus_idle();
    rst_n = 1'b1; cyc = 1'b1; stb = 1'b0; tgtsel = 4'h0; clr = 1'b0;
    t_ack = 1'b0; t_err = 1'b0; t_rty = 1'b0; t_stall = 1'b0;
  endtask

  task automatic unmapped(input logic [15:0] a);
    cyc = 1'b1; stb = 1'b1; tgtsel = 4'h0; adr = a;
  endtask

  task automatic do_reset();
    bus_idle(); cyc = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        cyc, stb;
    logic [3:0]  sel;
    logic        ts, ta, te, tr;
    logic [15:0] tdat;
    logic        e_tstb, e_stall, e_ack, e_err, e_rty;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1, 1, 4'b0001, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0};
    tbl[1] = '{1, 1, 4'b0100, 1, 0, 0, 0, 16'h0000, 1, 1, 0, 0, 0};
    tbl[2] = '{1, 1, 4'b0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0};
    tbl[3] = '{1, 0, 4'b1000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0};
    tbl[4] = '{0, 1, 4'b0010, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0};
    tbl[5] = '{1, 0, 4'b0000, 0, 1, 0, 0, 16'hA5A5, 0, 0, 1, 0, 0};
    tbl[6] = '{1, 0, 4'b0000, 0, 0, 1, 0, 16'h3C3C, 0, 0, 0, 1, 0};
    tbl[7] = '{1, 0, 4'b0000, 0, 0, 0, 1, 16'hFFFF, 0, 0, 0, 0, 1};

    we = 0; lock = 0; sel = 0; adr = 0; dat = 0; tga = 0; tgc = 0; tgdw = 0;
    t_dat = 0; t_tgd = 0;
    bus_idle();
    rst_n = 1'b0;
    @(negedge clk);

    // reset behaviour
    cyc = 1'b1; stb = 1'b1; tgtsel = 4'h1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_stall", d, d_stall[d], 1'b1);
      chk("rst_tcyc",  d, d_tcyc[d], 1'b0);
      chk("rst_tstb",  d, d_tstb[d], 1'b0);
    end
    step();
    for (int d = 0; d < 2; d++) chk("rst_cnt", d, d_cnt[d], 0);
    bus_idle(); cyc = 1'b0;
    step();

    // combinational pass-through table, idle with nothing outstanding
    for (int i = 0; i < 8; i++) begin
      bus_idle();
      cyc = tbl[i].cyc; stb = tbl[i].stb; tgtsel = tbl[i].sel; adr = 16'h1000 + 16'(i);
      t_stall = tbl[i].ts; t_ack = tbl[i].ta; t_err = tbl[i].te; t_rty = tbl[i].tr;
      t_dat = tbl[i].tdat;
      #1;
      for (int d = 0; d < 2; d++) begin
        chk("tbl_tstb",  d, d_tstb[d], tbl[i].e_tstb);
        chk("tbl_stall", d, d_stall[d], tbl[i].e_stall);
        chk("tbl_ack",   d, d_ack[d], tbl[i].e_ack);
        chk("tbl_err",   d, d_err[d], tbl[i].e_err);
        chk("tbl_rty",   d, d_rty[d], tbl[i].e_rty);
        chk("tbl_dat",   d, d_dato[d], tbl[i].tdat);
      end
      step();
      bus_idle(); cyc = 1'b0;
      step();
    end

    // single unmapped read at 0x1234
    do_reset();
    bus_idle(); unmapped(16'h1234);
    #1; chk("a_accept", 0, d_stall[0], 1'b0); chk("a_tstb", 0, d_tstb[0], 1'b0);
    step();
    bus_idle();
    #1; chk("a_err1", 0, d_err[0], 1'b1); chk("a_rty_early", 1, d_rty[1], 1'b0);
    step();
    #1; chk("a_err_one", 0, d_err[0], 1'b0); chk("a_cnt", 0, d_cnt[0], 1);
    chk("a_adr", 0, d_eadr[0], 16'h1234);
    step();
    #1; chk("a_rty3", 1, d_rty[1], 1'b1); chk("a_err_rtymode", 1, d_err[1], 1'b0);
    step();
    #1; chk("a_rty_one", 1, d_rty[1], 1'b0); chk("a_cnt1", 1, d_cnt[1], 1);
    step();

    // unmapped access waits for two forwarded accesses to retire
    bus_idle(); cyc = 1'b1; stb = 1'b1; tgtsel = 4'b0001; adr = 16'h0100;
    step(); step();
    unmapped(16'h0BAD);
    #1; chk("b_stall0", 0, d_stall[0], 1'b1); chk("b_tstb", 0, d_tstb[0], 1'b0);
    step();
    t_ack = 1'b1;
    #1; chk("b_stall1", 0, d_stall[0], 1'b1);
    step();
    #1; chk("b_stall2", 0, d_stall[0], 1'b1);
    step();
    t_ack = 1'b0;
    #1; chk("b_accept", 0, d_stall[0], 1'b0);
    step();
    stb = 1'b0;
    #1; chk("b_err", 0, d_err[0], 1'b1);
    step(); step();
    #1; chk("b_rty", 1, d_rty[1], 1'b1); chk("b_adr", 0, d_eadr[0], 16'h0BAD);
    step();
    bus_idle(); cyc = 1'b0; step();

    // outstanding limit on dut0: third access held until an ack
    bus_idle(); stb = 1'b1; tgtsel = 4'b0010; adr = 16'h0200;
    step(); step();
    #1; chk("c_full_stall", 0, d_stall[0], 1'b1); chk("c_full_tstb", 0, d_tstb[0], 1'b0);
    chk("c_d1_tstb", 1, d_tstb[1], 1'b1);
    step();
    t_ack = 1'b1;
    #1; chk("c_ack_stall", 0, d_stall[0], 1'b1); chk("c_ack_tstb", 0, d_tstb[0], 1'b0);
    step();
    t_ack = 1'b0;
    #1; chk("c_fwd_tstb", 0, d_tstb[0], 1'b1); chk("c_fwd_stall", 0, d_stall[0], 1'b0);
    step();
    bus_idle(); cyc = 1'b0; step();

    // cycle dropped while dut1 is delaying its retry
    do_reset();
    bus_idle(); unmapped(16'h0D0D); step();
    bus_idle(); step();
    cyc = 1'b0; step();
    cyc = 1'b1;
    #1; chk("d_no_rty", 1, d_rty[1], 1'b0);
    step();
    #1; chk("d_no_rty2", 1, d_rty[1], 1'b0); chk("d_cnt1", 1, d_cnt[1], 0);
    chk("d_cnt0", 0, d_cnt[0], 1);
    step();

    // counter saturation on dut0, then clear coinciding with a fault
    do_reset();
    for (int f = 0; f < 4; f++) begin
      bus_idle(); unmapped(16'h0E00 + 16'(f)); step();
      bus_idle(); step();
      #1; chk("e_sat", 0, d_cnt[0], (f < 3) ? f + 1 : 3);
      step(); step();
    end
    #1; chk("e_cnt_d1", 1, d_cnt[1], 4);
    unmapped(16'h0E04); step();
    bus_idle(); clr = 1'b1; step();
    clr = 1'b0;
    #1; chk("e_clr_inc", 0, d_cnt[0], 1);
    step(); step();
    #1; chk("e_clr_d1", 1, d_cnt[1], 1);
    step();

    // reset pulse during the delay
    bus_idle(); unmapped(16'h0F0F); step();
    bus_idle(); rst_n = 1'b0;
    #1; chk("f_err_sup", 0, d_err[0], 1'b0);
    for (int d = 0; d < 2; d++) chk("f_stall", d, d_stall[d], 1'b1);
    step();
    rst_n = 1'b1; step();
    #1; chk("f_no_rty", 1, d_rty[1], 1'b0);
    step();
    #1; chk("f_no_rty2", 1, d_rty[1], 1'b0);
    for (int d = 0; d < 2; d++) chk("f_cnt", d, d_cnt[d], 0);
    step();

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      int r;
      rst_n   = ($urandom_range(0, 99) != 0);
      cyc     = ($urandom_range(0, 19) != 0);
      stb     = ($urandom_range(0, 9) < 7);
      tgtsel  = ($urandom_range(0, 9) < 3) ? 4'h0 : 4'($urandom);
      adr     = 16'($urandom);
      dat     = 16'($urandom);
      we      = 1'($urandom); lock = 1'($urandom); sel = 2'($urandom);
      tga     = 1'($urandom); tgc = 1'($urandom); tgdw = 1'($urandom);
      t_stall = ($urandom_range(0, 3) == 0);
      r       = $urandom_range(0, 9);
      t_ack   = (r < 3); t_err = (r == 3); t_rty = (r == 4);
      t_dat   = 16'($urandom); t_tgd = 1'($urandom);
      clr     = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wbxbc_error_responder.md
# wbxbc_error_responder

Pipelined, parametrised error generator for the WbXbc crossbar, inserted between an initiator port and the crossbar's target-select fabric. Accesses with at least one target-select bit set pass through with zero latency. Accesses with no target selected are never forwarded; the block answers them itself with a configurable-latency ERR or RTY, and only after all earlier forwarded accesses have completed. It also keeps a saturating fault counter and captures the last faulting address.

## Interface
Parameters:
- TGT_CNT, 4, width of target-select tag
- ADR_WIDTH, 16, address width
- DAT_WIDTH, 16, data width
- SEL_WIDTH, 2, select width
- TGA_WIDTH, 1, address-tag width (excluding target select)
- TGC_WIDTH, 1, cycle-tag width
- TGRD_WIDTH, 1, read-data tag width
- TGWD_WIDTH, 1, write-data tag width
- MAX_OUTSTANDING, 4, maximum forwarded, unanswered accesses (≥1)
- ERR_LATENCY, 1, cycles from accepting an unmapped access to its response (≥1)
- RTY_MODE, 0, 0: respond with err, 1: respond with rty
- CNT_WIDTH, 8, fault counter width

Ports:
- clk_i in 1 module clock
- sync_rst_i in 1 reset; **one clock; reset is synchronous and active-low**
- itr_cyc_i, itr_stb_i, itr_we_i, itr_lock_i in 1 each, initiator control
- itr_sel_i / itr_adr_i / itr_dat_i in SEL_WIDTH / ADR_WIDTH / DAT_WIDTH
- itr_tga_i / itr_tga_tgtsel_i / itr_tgc_i / itr_tgd_i in TGA / TGT_CNT / TGC / TGWD widths
- itr_ack_o, itr_err_o, itr_rty_o, itr_stall_o out 1 each
- itr_dat_o / itr_tgd_o out DAT_WIDTH / TGRD_WIDTH
- tgt_* out: mirror of every itr_* input (cyc, stb, we, lock, sel, adr, dat, tga, tga_tgtsel, tgc, tgd)
- tgt_ack_i, tgt_err_i, tgt_rty_i, tgt_stall_i in 1 each; tgt_dat_i / tgt_tgd_i in DAT_WIDTH / TGRD_WIDTH
- err_cnt_o out CNT_WIDTH, generated-fault count, saturating
- err_adr_o out ADR_WIDTH, address of last accepted unmapped access
- err_clr_i in 1, clears err_cnt_o

## Operation
- mapped = |itr_tga_tgtsel_i; req = itr_cyc_i & itr_stb_i.
- Outstanding counter `out_cnt` (0..MAX_OUTSTANDING):
  - +1 on tgt_cyc_o & tgt_stb_o & ~tgt_stall_i.
  - −1 on tgt_ack_i|tgt_err_i|tgt_rty_i.
  - Both events in one cycle: unchanged.
  - A response while out_cnt=0 is forwarded but does not decrement (no underflow).
- FSM states:
  - IDLE
    - Unmapped req with out_cnt=0: accept (itr_stall_o=0), capture itr_adr_i into err_adr_o, go to DELAY (ERR_LATENCY>1) or RESP (ERR_LATENCY=1).
    - Unmapped req with out_cnt>0: itr_stall_o=1, stay in IDLE.
  - DELAY: count ERR_LATENCY−1 cycles, then go to RESP.
  - RESP: assert itr_err_o (RTY_MODE=0) or itr_rty_o (RTY_MODE=1) for one cycle; increment err_cnt_o; return to IDLE.
- Forwarding:
  - tgt_cyc_o=itr_cyc_i.
  - tgt_stb_o = req & mapped & state==IDLE & out_cnt<MAX_OUTSTANDING.
  - All other tgt_* outputs are combinational copies of the itr_* inputs.
- Stall: itr_stall_o = 1 whenever state≠IDLE. In IDLE:
  - mapped: itr_stall_o = tgt_stall_i | (out_cnt==MAX_OUTSTANDING).
  - unmapped: itr_stall_o = (out_cnt≠0).
- Response merge:
  - itr_ack_o=tgt_ack_i.
  - itr_err_o = tgt_err_i | gen_err; itr_rty_o = tgt_rty_i | gen_rty.
  - itr_dat_o=tgt_dat_i, itr_tgd_o=tgt_tgd_i.
  - Generated and target responses cannot coincide, because an error is accepted only at out_cnt=0 and no forwarding occurs until RESP ends.
- itr_cyc_i low in any state aborts: FSM→IDLE, out_cnt→0, no generated response, err_cnt_o unchanged.
- err_cnt_o:
  - Saturates at all-ones.
  - err_clr_i clears it.
  - err_clr_i coinciding with an increment yields 1.
- Reset (sync_rst_i=0 at posedge):
  - FSM→IDLE; out_cnt, err_cnt_o, err_adr_o→0.
  - While sync_rst_i is low: tgt_cyc_o=tgt_stb_o=0, itr_stall_o=1, generated err/rty=0. Target responses are still forwarded.

## Timing
- Mapped path: zero-cycle combinational in both directions.
- Unmapped access accepted at edge N: generated response is high during cycle N+ERR_LATENCY, exactly one cycle wide.
- Next access is accepted no earlier than edge N+ERR_LATENCY+1.
- At out_cnt=MAX_OUTSTANDING, stall is asserted even if a response arrives in the same cycle (conservative).
- Reset mid-DELAY/RESP: response suppressed from the next cycle on.

## Test plan
- ERR_LATENCY=1, unmapped read adr 0x1234 at edge 0 with out_cnt=0 -> itr_err_o=1 in cycle 1 only, err_cnt_o=1, err_adr_o=0x1234, tgt_stb_o never high.
- Two mapped accesses forwarded (out_cnt=2), then unmapped req -> itr_stall_o=1 until both tgt_ack_i seen; err follows ERR_LATENCY cycles after acceptance, after the second ack.
- MAX_OUTSTANDING=2, target never acks, 3 mapped reqs -> third stalled, tgt_stb_o low; one ack -> third forwarded next cycle.
- RTY_MODE=1, ERR_LATENCY=3, unmapped req at edge 0 -> itr_rty_o high cycle 3, itr_err_o stays 0; itr_cyc_i dropped at cycle 2 in a repeat -> no rty, err_cnt_o unchanged.
- CNT_WIDTH=2, 4 unmapped faults -> err_cnt_o 1,2,3,3; err_clr_i coinciding with a 5th fault -> err_cnt_o=1.
- sync_rst_i low for one edge during DELAY -> no generated response, err_cnt_o=0, itr_stall_o=1 while reset is low.
